// File: rtl/pio_in_edge_capture_if.sv
// rtl/pio_in_edge_capture_if.sv - Avalon-MM register bus and interrupt bundle for pio_in_edge_capture
interface pio_in_edge_capture_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/pio_in_edge_capture.sv
// rtl/pio_in_edge_capture.sv - synchronised PIO input with sticky edge capture and masked irq
// PIO_IN_BIT_CLEAR_EN: EDGECAP writes clear only the writedata bits (otherwise any write clears all).
module pio_in_edge_capture #(
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    pio_in_edge_capture_if.slave  bus,
    input  logic [DATA_WIDTH-1:0] in_port
);
    localparam int               ARM_MAX = SYNC_STAGES + 1;
    localparam int               ARM_W   = $clog2(ARM_MAX + 1);
    localparam logic [ARM_W-1:0] ARM_SAT = ARM_W'(ARM_MAX);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
    logic [DATA_WIDTH-1:0] data_prev_q, data_prev_d;
    logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
    logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
    logic [ARM_W-1:0]      arm_q, arm_d;
    logic [31:0]           readdata_q, readdata_d;

    logic [DATA_WIDTH-1:0] data_sync;
    logic [DATA_WIDTH-1:0] edge_raw;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  armed;
    logic                  wr_en;
    logic                  unused_wdata;

    assign data_sync    = sync_q[SYNC_STAGES-1];
    assign armed        = (arm_q == ARM_SAT);
    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[DATA_WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            0:       edge_raw = data_sync & ~data_prev_q;
            1:       edge_raw = ~data_sync & data_prev_q;
            default: edge_raw = data_sync ^ data_prev_q;
        endcase
        // data_prev is not meaningful until the chain has flushed the reset zeros
        edge_det = armed ? edge_raw : '0;
    end

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], in_port};
        data_prev_d = data_sync;
        arm_d       = armed ? arm_q : arm_q + 1'b1;
        irqmask_d   = irqmask_q;
        edgecap_d   = edgecap_q;

        if (wr_en && bus.address == 2'd2) begin
            irqmask_d = wdata;
        end
        if (wr_en && bus.address == 2'd3) begin
`ifdef PIO_IN_BIT_CLEAR_EN
            edgecap_d = edgecap_q & ~wdata;
`else
            edgecap_d = '0;
`endif
        end
        // a new edge in the same cycle as a clear must survive the clear
        edgecap_d = edgecap_d | edge_det;

        readdata_d = '0;
        case (bus.address)
            2'd0:    readdata_d = 32'(data_sync);
            2'd1:    readdata_d = 32'(data_prev_q);
            2'd2:    readdata_d = 32'(irqmask_q);
            default: readdata_d = 32'(edgecap_q);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            data_prev_q <= '0;
            irqmask_q   <= '0;
            edgecap_q   <= '0;
            arm_q       <= '0;
            readdata_q  <= '0;
        end else begin
            sync_q      <= sync_d;
            data_prev_q <= data_prev_d;
            irqmask_q   <= irqmask_d;
            edgecap_q   <= edgecap_d;
            arm_q       <= arm_d;
            readdata_q  <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edgecap_q & irqmask_q);
endmodule

// File: tb/tb_pio_in_edge_capture.sv
// tb/tb_pio_in_edge_capture.sv - randomized and directed self-checking bench for pio_in_edge_capture
module tb_pio_in_edge_capture;
    localparam int S  = 2;
    localparam int W0 = 12;
    localparam int W1 = 32;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic [1:0]    address    = '0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = '0;
    logic [W0-1:0] in0        = '0;
    logic [W1-1:0] in1        = '0;
    int            checks     = 0;
    int            errors     = 0;

    pio_in_edge_capture_if bus0 ();
    pio_in_edge_capture_if bus1 ();

    assign bus0.address    = address;
    assign bus0.chipselect = chipselect;
    assign bus0.write_n    = write_n;
    assign bus0.writedata  = writedata;
    assign bus1.address    = address;
    assign bus1.chipselect = chipselect;
    assign bus1.write_n    = write_n;
    assign bus1.writedata  = writedata;

    pio_in_edge_capture #(.DATA_WIDTH(W0), .SYNC_STAGES(S), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .in_port(in0)
    );
    pio_in_edge_capture #(.DATA_WIDTH(W1), .SYNC_STAGES(S), .EDGE_TYPE(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .in_port(in1)
    );

    always #5 clk = ~clk;

    // Reference: value of in_port sampled at every edge since reset release; the
    // synchronised view after m edges is simply the sample taken S edges earlier.
    logic [31:0] hist0 [$];
    logic [31:0] hist1 [$];
    logic [31:0] m_cap  [2] = '{32'h0, 32'h0};
    logic [31:0] m_mask [2] = '{32'h0, 32'h0};
    logic [31:0] m_rd   [2] = '{32'h0, 32'h0};
    logic [31:0] m_edge, m_wmask;
    int          m_cnt = 0;

    function automatic logic [31:0] sync_at(int k, int m);
        if (m < S) return 32'h0;
        return (k == 0) ? hist0[m-S] : hist1[m-S];
    endfunction

    function automatic logic [31:0] edges_at(int k, int m);
        logic [31:0] now_v, old_v;
        if (m < S + 1) return 32'h0;
        now_v = sync_at(k, m);
        old_v = sync_at(k, m - 1);
        if (k == 0) return now_v & ~old_v;
        return now_v ^ old_v;
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            hist0.delete();
            hist1.delete();
            m_cnt = 0;
            for (int k = 0; k < 2; k++) begin
                m_cap[k] = 0; m_mask[k] = 0; m_rd[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_wmask = (k == 0) ? 32'h0000_0FFF : 32'hFFFF_FFFF;
                m_edge  = edges_at(k, m_cnt);
                case (address)
                    2'd0:    m_rd[k] = sync_at(k, m_cnt);
                    2'd1:    m_rd[k] = sync_at(k, m_cnt - 1);
                    2'd2:    m_rd[k] = m_mask[k];
                    default: m_rd[k] = m_cap[k];
                endcase
                if (chipselect && !write_n && address == 2'd2) m_mask[k] = writedata & m_wmask;
                if (chipselect && !write_n && address == 2'd3) begin
`ifdef PIO_IN_BIT_CLEAR_EN
                    m_cap[k] = m_cap[k] & ~writedata;
`else
                    m_cap[k] = 32'h0;
`endif
                end
                m_cap[k] = m_cap[k] | m_edge;
            end
            hist0.push_back(32'(in0));
            hist1.push_back(in1);
            m_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        check("cyc_rd0", bus0.readdata, m_rd[0]);
        check("cyc_rd1", bus1.readdata, m_rd[1]);
        check("cyc_irq0", 32'(bus0.irq), 32'(|(m_cap[0] & m_mask[0])));
        check("cyc_irq1", 32'(bus1.irq), 32'(|(m_cap[1] & m_mask[1])));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = $urandom();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r0, output logic [31:0] r1);
        @(negedge clk);
        address = a;
        @(negedge clk);
        r0 = bus0.readdata;
        r1 = bus1.readdata;
    endtask

    logic [31:0] r0, r1;

    initial begin
        in0 = 12'hFFF;
        in1 = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check("rst_rd0", bus0.readdata, 32'h0);
        check("rst_irq0", 32'(bus0.irq), 32'h0);
        reset = 1'b0;

        // static high levels at reset release must not look like edges
        idle(10);
        rd(2'd3, r0, r1);
        check("static_cap0", r0, 32'h0);
        check("static_cap1", r1, 32'h0);
        check("static_irq0", 32'(bus0.irq), 32'h0);
        rd(2'd0, r0, r1);
        check("static_data0", r0, 32'h0000_0FFF);
        check("static_data1", r1, 32'hFFFF_FFFF);

        // DATA latency counted in edges, the capturing edge being the first
        in0 = 12'h5A5;
        repeat (S) @(negedge clk);
        check("lat_old", bus0.readdata, 32'h0000_0FFF);
        @(negedge clk);
        check("lat_new", bus0.readdata, 32'h0000_05A5);

        in0 = 12'h000;
        idle(6);
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'h0000_0001);
        in0 = 12'h001;
        repeat (S + 2) @(negedge clk);
        check("rise_irq", 32'(bus0.irq), 32'h1);
        rd(2'd3, r0, r1);
        check("rise_cap", r0, 32'h0000_0001);
        in0 = 12'h000;
        idle(6);
        rd(2'd3, r0, r1);
        check("fall_keep", r0, 32'h0000_0001);

        in0 = 12'h003;
        idle(6);
        rd(2'd3, r0, r1);
        check("cap3", r0, 32'h0000_0003);
        wr(2'd3, 32'h0000_0001);
        rd(2'd3, r0, r1);
`ifdef PIO_IN_BIT_CLEAR_EN
        check("clear_bit0", r0, 32'h0000_0002);
`else
        check("clear_all", r0, 32'h0000_0000);
`endif

        // clear write lands on the same edge that captures a new rising edge
        in0 = 12'h000;
        idle(6);
        in0 = 12'h001;
        repeat (S - 1) @(negedge clk);
        wr(2'd3, 32'h0000_0001);
        check("edge_wins_irq", 32'(bus0.irq), 32'h1);
        rd(2'd3, r0, r1);
        check("edge_wins_cap", r0 & 32'h1, 32'h1);

        wr(2'd2, 32'h0);
        in1 = 32'h0;
        idle(6);
        wr(2'd3, 32'hFFFF_FFFF);
        in1 = 32'hA5A5_A5A5;
        idle(6);
        rd(2'd3, r0, r1);
        check("any_cap1", r1, 32'hA5A5_A5A5);
        check("any_irq1", 32'(bus1.irq), 32'h0);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom();
            if ($urandom_range(0, 2) == 0) in0 = in0 ^ (12'(1) << $urandom_range(0, W0 - 1));
            if ($urandom_range(0, 2) == 0) in1 = in1 ^ (32'(1) << $urandom_range(0, W1 - 1));
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        // asynchronous reset with interrupt pending
        in1 = 32'h0;
        wr(2'd2, 32'h0000_0FFF);
        in0 = 12'h000;
        idle(6);
        wr(2'd3, 32'hFFFF_FFFF);
        in0 = 12'hFFF;
        idle(6);
        rd(2'd3, r0, r1);
        check("full_cap0", r0, 32'h0000_0FFF);
        check("full_irq0", 32'(bus0.irq), 32'h1);
        in0 = 12'h000;
        idle(6);
        #2 reset = 1'b1;
        #1;
        check("async_irq0", 32'(bus0.irq), 32'h0);
        check("async_rd0", bus0.readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), r0, r1);
            check("post_rst_reg", r0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
